pc_sequencer: RTL

Control FSM that drives the program-counter `counter` instance in the fetch path. It owns the counter's `sel_in`/`in`/`dec` controls and issues fetch requests to instruction memory. It applies redirects (branch, call, return, interrupt, replay) and keeps a small internal return-address stack (RAS). The counter increments on every edge unless loaded, so this block holds the PC by reloading `pc_q`.

---
 rtl/pc_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: control FSM that steers the fetch-path program counter.
// It drives the counter's load/decrement controls, issues fetch requests,
// applies redirects (interrupt, return, call, branch, replay) in a fixed
// priority, and keeps a small circular return-address stack (RAS).
// The counter increments on every edge unless loaded, so "hold" here means
// reloading the counter with its own current value.

module pc_sequencer #(
  parameter int               WIDTH        = 8,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] IRQ_VECTOR   = WIDTH'('hF0)
) (
  input  logic             clk,
  input  logic             reset,          // asynchronous, active low

  // Program-counter instance
  input  logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] pc_in,
  output logic             pc_sel_in,
  output logic             pc_dec,

  // Instruction memory
  output logic             fetch_req,
  output logic [WIDTH-1:0] fetch_addr,
  input  logic             fetch_ack,
  output logic             flush,

  // Back end and redirect sources
  input  logic             stall,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call_valid,
  input  logic [WIDTH-1:0] call_target,
  input  logic             ret_valid,
  input  logic             replay,

  // Interrupt and status
  input  logic             irq,
  output logic             irq_ack,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_FETCH   = 2'd1,
    S_STALLED = 2'd2,
    S_IRQ     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               in_isr_q, in_isr_d;

  // Return-address stack: ras_ptr_q points at the next free slot, so the
  // top of stack lives one entry below it. When full, a push simply wraps
  // and overwrites the oldest entry.
  logic [WIDTH-1:0]   ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr_q;
  logic [CNT_W-1:0]   ras_cnt_q;
  logic               ras_overflow_q;
  logic               ras_underflow_q;

  logic               ras_push;
  logic               ras_pop;
  logic               ras_empty;
  logic               ras_full;
  logic [WIDTH-1:0]   ras_top;
  logic               redirect;

  assign ras_empty     = (ras_cnt_q == '0);
  assign ras_full      = (ras_cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_top       = ras_q[ras_ptr_q - PTR_W'(1)];

  assign fetch_addr    = pc_q;
  assign ras_overflow  = ras_overflow_q;
  assign ras_underflow = ras_underflow_q;

  // Next-state and counter-control decode; one event is taken per cycle.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so
    // that no path leaves a value unassigned, which would infer a latch.
    state_d   = state_q;
    in_isr_d  = in_isr_q;
    pc_sel_in = 1'b1;
    pc_in     = pc_q;
    pc_dec    = 1'b0;
    fetch_req = 1'b0;
    flush     = 1'b0;
    irq_ack   = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    redirect  = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        pc_in   = RESET_VECTOR;
        state_d = S_FETCH;
      end

      S_IRQ: begin
        // The interrupted PC was held last cycle and is saved here.
        ras_push = 1'b1;
        pc_in    = IRQ_VECTOR;
        irq_ack  = 1'b1;
        in_isr_d = 1'b1;
        state_d  = S_FETCH;
      end

      S_FETCH, S_STALLED: begin
        fetch_req = (state_q == S_FETCH);

        if (irq && !in_isr_q) begin
          // PC holds this cycle; the vector is loaded from the IRQ state.
          redirect = 1'b1;
          state_d  = S_IRQ;
        end else if (ret_valid) begin
          redirect = 1'b1;
          ras_pop  = 1'b1;
          in_isr_d = 1'b0;
          pc_in    = ras_empty ? RESET_VECTOR : ras_top;
          state_d  = S_FETCH;
        end else if (call_valid) begin
          redirect = 1'b1;
          ras_push = 1'b1;
          pc_in    = call_target;
          state_d  = S_FETCH;
        end else if (branch_valid) begin
          redirect = 1'b1;
          pc_in    = branch_target;
          state_d  = S_FETCH;
        end else if (replay) begin
          redirect  = 1'b1;
          pc_sel_in = 1'b0;
          pc_dec    = 1'b1;
          state_d   = S_FETCH;
        end else if (state_q == S_FETCH) begin
          if (fetch_ack) begin
            // Let the counter step to PC+1.
            pc_sel_in = 1'b0;
            state_d   = stall ? S_STALLED : S_FETCH;
          end
        end else if (!stall) begin
          state_d = S_FETCH;
        end

        // The instruction returned alongside a redirect is on the wrong path.
        flush = redirect && fetch_req && fetch_ack;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // FSM state and in-ISR marker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_BOOT;
      in_isr_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of block ordering.
      state_q  <= state_d;
      in_isr_q <= in_isr_d;
    end
  end

  // RAS pointer, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr_q       <= '0;
      ras_cnt_q       <= '0;
      ras_overflow_q  <= 1'b0;
      ras_underflow_q <= 1'b0;
    end else if (ras_push) begin
      ras_ptr_q <= ras_ptr_q + PTR_W'(1);
      if (ras_full) begin
        ras_overflow_q <= 1'b1;
      end else begin
        ras_cnt_q <= ras_cnt_q + CNT_W'(1);
      end
    end else if (ras_pop) begin
      if (ras_empty) begin
        ras_underflow_q <= 1'b1;
      end else begin
        ras_ptr_q <= ras_ptr_q - PTR_W'(1);
        ras_cnt_q <= ras_cnt_q - CNT_W'(1);
      end
    end
  end

  // RAS storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the stack array is deliberately not reset; emptiness is tracked
    // by ras_cnt_q alone, so stale entries are never read.
    if (ras_push) begin
      ras_q[ras_ptr_q] <= pc_q;
    end
  end

endmodule
